// File: rtl/seq_detect_pkg.sv
// Shared types and default sizing for the serial run detector controller.
package seq_detect_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } state_e;

   localparam int unsigned DefWidth  = 6;
   localparam int unsigned DefRunLen = 3;

endpackage

// File: rtl/run_detector.sv
// Mealy detector: z fires on the current 1 once RUN_LEN consecutive 1s have been seen.
module run_detector #(
   parameter int unsigned RUN_LEN = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic bit_en,
   input  logic bit_in,
   output logic z
);

   localparam int unsigned     RunW   = $clog2(RUN_LEN);
   localparam logic [RunW-1:0] RunMax = RunW'(RUN_LEN - 1);

   logic [RunW-1:0] run_q, run_d;

   always_comb begin
      run_d = run_q;
      if (clr) begin
         run_d = '0;
      end else if (bit_en) begin
         if (!bit_in)               run_d = '0;
         else if (run_q != RunMax)  run_d = run_q + RunW'(1);
      end
   end

   assign z = bit_en && bit_in && (run_q >= RunMax);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) run_q <= '0;
      else      run_q <= run_d;
   end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Feeds accepted words LSB first into run_detector and reports hit mask/count.
// Define STREAM_CONT_EN to let runs of 1s continue across word boundaries.
module seq_detect_ctrl
   import seq_detect_pkg::*;
#(
   parameter  int unsigned WIDTH   = DefWidth,
   parameter  int unsigned RUN_LEN = DefRunLen,
   localparam int unsigned CNT_W   = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] hit_mask,
   output logic [CNT_W-1:0] hit_count
);

   localparam int unsigned     IdxW    = $clog2(WIDTH);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [IdxW-1:0]  idx_q, idx_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic accept, det_clr, det_en, det_z;

   assign accept = (state_q == StIdle) && in_valid;
   assign det_en = (state_q == StShift);

`ifdef STREAM_CONT_EN
   assign det_clr = 1'b0;
`else
   assign det_clr = accept;
`endif

   run_detector #(
      .RUN_LEN (RUN_LEN)
   ) u_run_detector (
      .clk    (clk),
      .rst    (rst),
      .clr    (det_clr),
      .bit_en (det_en),
      .bit_in (shreg_q[0]),
      .z      (det_z)
   );

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      idx_d   = idx_q;
      mask_d  = mask_q;
      count_d = count_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               shreg_d = in_data;
               idx_d   = '0;
               mask_d  = '0;
               count_d = '0;
               state_d = StShift;
            end
         end
         StShift: begin
            shreg_d = shreg_q >> 1;
            idx_d   = idx_q + IdxW'(1);
            if (det_z) begin
               mask_d[idx_q] = 1'b1;
               count_d       = count_q + CNT_W'(1);
            end
            if (idx_q == IdxLast) state_d = StDone;
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         shreg_q <= '0;
         idx_q   <= '0;
         mask_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
         mask_q  <= mask_d;
         count_q <= count_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign busy      = (state_q != StIdle);
   assign out_valid = (state_q == StDone);
   assign hit_mask  = mask_q;
   assign hit_count = count_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: per-cycle model compare plus directed literals.
module tb_seq_detect_ctrl;

   localparam int unsigned WIDTH   = 6;
   localparam int unsigned RUN_LEN = 3;
   localparam int unsigned CNT_W   = $clog2(WIDTH + 1);

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid, in_ready, busy, out_valid, out_ready;
   logic [WIDTH-1:0] in_data, hit_mask;
   logic [CNT_W-1:0] hit_count;

   logic             in_valid2, in_ready2, busy2, out_valid2, out_ready2;
   logic [WIDTH-1:0] in_data2, hit_mask2;
   logic [CNT_W-1:0] hit_count2;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   seq_detect_ctrl #(.WIDTH(WIDTH), .RUN_LEN(RUN_LEN)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .hit_mask  (hit_mask),
      .hit_count (hit_count)
   );

   seq_detect_ctrl #(.WIDTH(WIDTH), .RUN_LEN(2)) dut2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid2),
      .in_ready  (in_ready2),
      .in_data   (in_data2),
      .busy      (busy2),
      .out_valid (out_valid2),
      .out_ready (out_ready2),
      .hit_mask  (hit_mask2),
      .hit_count (hit_count2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: count consecutive 1s as a plain integer; a bit hits once the count reaches RUN_LEN.
   function automatic logic [WIDTH-1:0] scan_mask(input logic [WIDTH-1:0] w, input int run_in);
      int r;
      logic [WIDTH-1:0] m;
      r = run_in;
      m = '0;
      for (int k = 0; k < WIDTH; k++) begin
         if (w[k]) begin
            r++;
            if (r >= RUN_LEN) m[k] = 1'b1;
         end else begin
            r = 0;
         end
      end
      return m;
   endfunction

   function automatic int scan_run(input logic [WIDTH-1:0] w, input int run_in);
      int r;
      r = run_in;
      for (int k = 0; k < WIDTH; k++) r = w[k] ? r + 1 : 0;
      return r;
   endfunction

   logic             m_active;
   int               m_cnt;
   logic [WIDTH-1:0] m_full;
   int               m_run;
   int               run_seed;

`ifdef STREAM_CONT_EN
   always_comb run_seed = m_run;
`else
   always_comb run_seed = 0;
`endif

   // m_cnt counts edges since accept; the result bits appear one per edge until WIDTH.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_active <= 1'b0;
         m_cnt    <= 0;
         m_full   <= '0;
         m_run    <= 0;
      end else if (!m_active) begin
         if (in_valid) begin
            m_active <= 1'b1;
            m_cnt    <= 0;
            m_full   <= scan_mask(in_data, run_seed);
            m_run    <= scan_run(in_data, run_seed);
         end
      end else if (m_cnt >= WIDTH) begin
         if (out_ready) m_active <= 1'b0;
      end else begin
         m_cnt <= m_cnt + 1;
      end
   end

   logic [31:0]      low_bits;
   logic [WIDTH-1:0] exp_mask;
   always_comb begin
      low_bits = (32'd1 << m_cnt) - 32'd1;
      exp_mask = m_full & low_bits[WIDTH-1:0];
   end

   always @(negedge clk) begin
      check("in_ready", 32'(in_ready), 32'(!m_active));
      check("busy", 32'(busy), 32'(m_active));
      check("out_valid", 32'(out_valid), 32'(m_active && (m_cnt == WIDTH)));
      check("hit_mask", 32'(hit_mask), 32'(exp_mask));
      check("hit_count", 32'(hit_count), 32'($countones(exp_mask)));
   end

   task automatic send_word(input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] emask,
                            input int ecnt, input int hold);
      int n;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = w;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("latency", 32'(n), 32'(WIDTH));
      check("lit_mask", 32'(hit_mask), 32'(emask));
      check("lit_count", 32'(hit_count), 32'(ecnt));
      for (int i = 0; i < hold; i++) begin
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_mask", 32'(hit_mask), 32'(emask));
         check("bp_count", 32'(hit_count), 32'(ecnt));
         in_valid = (i == 3);
         in_data  = ~w;
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("rel_in_ready", 32'(in_ready), 32'd1);
      check("rel_out_valid", 32'(out_valid), 32'd0);
      check("rel_mask", 32'(hit_mask), 32'(emask));
   endtask

   initial begin
      int n;
      in_valid   = 1'b0;
      in_data    = '0;
      out_ready  = 1'b0;
      in_valid2  = 1'b0;
      in_data2   = '0;
      out_ready2 = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_mask", 32'(hit_mask), 32'd0);
      check("rst_count", 32'(hit_count), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      send_word(6'b111010, 6'b100000, 1, 0);
      send_word(6'b000000, 6'b000000, 0, 0);
      send_word(6'b111111, 6'b111100, 4, 0);
      send_word(6'b000000, 6'b000000, 0, 0);
      send_word(6'b010101, 6'b000000, 0, 10);
      send_word(6'b110000, 6'b000000, 0, 0);
`ifdef STREAM_CONT_EN
      send_word(6'b000001, 6'b000001, 1, 0);
`else
      send_word(6'b000001, 6'b000000, 0, 0);
`endif

      // Abort during the third SHIFT cycle of an all-ones word.
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 6'b111111;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("mid_in_ready", 32'(in_ready), 32'd1);
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_out_valid", 32'(out_valid), 32'd0);
      check("mid_mask", 32'(hit_mask), 32'd0);
      check("mid_count", 32'(hit_count), 32'd0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      repeat (8) begin
         @(negedge clk);
         check("post_rst_valid", 32'(out_valid), 32'd0);
         check("post_rst_ready", 32'(in_ready), 32'd1);
      end
      send_word(6'b000111, 6'b000100, 1, 0);
      send_word(6'b011011, 6'b000000, 0, 0);

      // RUN_LEN=2 instance.
      @(negedge clk);
      in_valid2 = 1'b1;
      in_data2  = 6'b011011;
      @(posedge clk);
      @(negedge clk);
      in_valid2 = 1'b0;
      n = 0;
      while (!out_valid2 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("r2_latency", 32'(n), 32'(WIDTH));
      check("r2_mask", 32'(hit_mask2), 32'(6'b010010));
      check("r2_count", 32'(hit_count2), 32'd2);
      out_ready2 = 1'b1;
      @(negedge clk);
      out_ready2 = 1'b0;
      check("r2_in_ready", 32'(in_ready2), 32'd1);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
